// File: rtl/logic_ops_pkg.sv
// logic_ops_pkg
//   Shared definitions for the logic-op slice of the LittleComputer.
//   Holds the op-field width and the op-code encoding used by the
//   combinational core and the pipelined wrapper.
package logic_ops_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core
//   Purely combinational multi-channel bitwise logic unit.
//   Ports:
//     op     - operation select (logic_ops_pkg::op_e encoding)
//     data   - CHANNELS packed operands, channel i at [i*WIDTH +: WIDTH]
//     result - selected bitwise result
//     zero   - result is all zeros
//     ones   - result is all ones
module logic_unit_core
  import logic_ops_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic [OP_W-1:0]           op,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]          result,
  output logic                      zero,
  output logic                      ones
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  logic [WIDTH-1:0] chan0;

  assign chan0 = data[WIDTH-1:0];

  // Reductions run across every channel; XOR therefore gives odd parity
  // per bit position.
  always_comb begin
    and_r = chan0;
    or_r  = chan0;
    xor_r = chan0;
    for (int i = 1; i < CHANNELS; i++) begin
      and_r = and_r & data[i*WIDTH +: WIDTH];
      or_r  = or_r  | data[i*WIDTH +: WIDTH];
      xor_r = xor_r ^ data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = and_r;
    case (op_e'(op))
      OP_AND:  result = and_r;
      OP_OR:   result = or_r;
      OP_XOR:  result = xor_r;
      OP_NAND: result = ~and_r;
      OP_NOR:  result = ~or_r;
      OP_XNOR: result = ~xor_r;
      OP_NOT:  result = ~chan0;
      OP_PASS: result = chan0;
      default: result = and_r;
    endcase
  end

  assign zero = ~|result;
  assign ones = &result;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Logic-op slice with a 2-entry registered output buffer and
//   valid/ready handshakes on both sides.
//   Ports:
//     clk       - rising-edge clock
//     reset_n   - asynchronous active-low reset
//     in_valid  - operands and op present
//     in_ready  - buffer has room (registered count only)
//     in_op     - operation select
//     in_data   - CHANNELS packed WIDTH-bit operands
//     out_valid - head entry valid
//     out_ready - consumer takes head entry
//     out_data  - head result
//     out_zero  - head result was all zeros
//     out_ones  - head result was all ones
module logic_unit_pipe
  import logic_ops_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_op,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_zero,
  output logic                      out_ones
);

  if (WIDTH < 1 || CHANNELS < 2) begin : g_param_check
    $error("logic_unit_pipe: WIDTH must be >= 1 and CHANNELS >= 2");
  end

  // Entry layout: {zero, ones, result}
  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ones;
  logic [EW-1:0]    new_entry;
  logic [EW-1:0]    head;
  logic [EW-1:0]    tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  logic_unit_core #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_core (
    .op     (in_op),
    .data   (in_data),
    .result (core_result),
    .zero   (core_zero),
    .ones   (core_ones)
  );

  assign new_entry = {core_zero, core_ones, core_result};

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = head[WIDTH-1:0];
  assign out_ones  = head[WIDTH];
  assign out_zero  = head[WIDTH+1];

  // Head is always the oldest entry; a pop shifts tail forward. A push
  // together with a pop can only happen at count=1, so the new entry
  // lands directly in head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= new_entry;
          else               tail <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          head <= new_entry;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe
//   Directed bench for logic_unit_pipe: a WIDTH=4/CHANNELS=2 instance for
//   ops, flags, handshake and reset, plus a WIDTH=4/CHANNELS=3 instance for
//   multi-channel reductions.
module tb_logic_unit_pipe;
  import logic_ops_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_zero;
  logic        out_ones;

  logic        in_valid3;
  logic        in_ready3;
  logic [2:0]  in_op3;
  logic [11:0] in_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [3:0]  out_data3;
  logic        out_zero3;
  logic        out_ones3;

  int check_count = 0;
  int error_count = 0;

  // A=1100, B=1010 for ops 0..7
  int op_exp [8] = '{8, 14, 6, 7, 1, 9, 3, 12};

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(4), .CHANNELS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_ones  (out_ones)
  );

  logic_unit_pipe #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_op     (in_op3),
    .in_data   (in_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .out_zero  (out_zero3),
    .out_ones  (out_ones3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [3:0] a, input logic [3:0] b);
    in_valid = valid;
    in_op    = op;
    in_data  = {b, a};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    out_ready  = 1'b1;
    applyStimulus(1'b1, OP_AND, 4'b1100, 4'b1010);
    in_valid3  = 1'b0;
    in_op3     = 3'd0;
    in_data3   = 12'd0;
    out_ready3 = 1'b1;

    // Reset held with in_valid high
    repeat (2) step();
    checkOutput("rst out_valid", 32'(out_valid), 0);
    checkOutput("rst out_data",  32'(out_data),  0);
    checkOutput("rst out_zero",  32'(out_zero),  0);
    checkOutput("rst out_ones",  32'(out_ones),  0);
    checkOutput("rst in_ready",  32'(in_ready),  1);

    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();
    checkOutput("post-rst out_valid", 32'(out_valid), 0);
    checkOutput("post-rst in_ready",  32'(in_ready),  1);

    // All eight ops, back to back; each result one cycle after accept
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 4'b1100, 4'b1010);
      step();
      checkOutput($sformatf("op%0d valid", i), 32'(out_valid), 1);
      checkOutput($sformatf("op%0d data", i),  32'(out_data),  32'(op_exp[i]));
    end
    in_valid = 1'b0;
    step();
    checkOutput("ops drained", 32'(out_valid), 0);

    // Flags
    applyStimulus(1'b1, OP_OR, 4'b0000, 4'b0000);
    step();
    checkOutput("flag or0 data", 32'(out_data), 0);
    checkOutput("flag or0 zero", 32'(out_zero), 1);
    checkOutput("flag or0 ones", 32'(out_ones), 0);
    applyStimulus(1'b1, OP_AND, 4'b1111, 4'b1111);
    step();
    checkOutput("flag and1 data", 32'(out_data), 15);
    checkOutput("flag and1 zero", 32'(out_zero), 0);
    checkOutput("flag and1 ones", 32'(out_ones), 1);
    in_valid = 1'b0;
    step();

    // Three channels: 1100, 1010, 0110
    in_valid3 = 1'b1;
    in_data3  = {4'b0110, 4'b1010, 4'b1100};
    in_op3    = OP_XOR;
    step();
    checkOutput("ch3 xor data", 32'(out_data3), 0);
    checkOutput("ch3 xor zero", 32'(out_zero3), 1);
    in_op3 = OP_AND;
    step();
    checkOutput("ch3 and data", 32'(out_data3), 0);
    in_op3 = OP_OR;
    step();
    checkOutput("ch3 or data",  32'(out_data3), 14);
    checkOutput("ch3 or zero",  32'(out_zero3), 0);
    in_valid3 = 1'b0;
    step();
    checkOutput("ch3 drained", 32'(out_valid3), 0);

    // Backpressure
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_PASS, 4'd1, 4'd0);
    checkOutput("bp ready1", 32'(in_ready), 1);
    step();
    applyStimulus(1'b1, OP_PASS, 4'd2, 4'd0);
    checkOutput("bp ready2", 32'(in_ready), 1);
    step();
    applyStimulus(1'b1, OP_PASS, 4'd3, 4'd0);
    checkOutput("bp ready3", 32'(in_ready), 0);
    step();
    checkOutput("bp full ready", 32'(in_ready), 0);
    checkOutput("bp head1",      32'(out_data), 1);
    out_ready = 1'b1;
    step();
    checkOutput("bp head2",  32'(out_data), 2);
    checkOutput("bp reopen", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    checkOutput("bp head3",  32'(out_data),  3);
    checkOutput("bp valid3", 32'(out_valid), 1);
    step();
    checkOutput("bp empty", 32'(out_valid), 0);

    // Streaming with no bubbles
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, OP_PASS, 4'(i + 1), 4'd0);
      checkOutput($sformatf("stream%0d ready", i), 32'(in_ready), 1);
      step();
      checkOutput($sformatf("stream%0d valid", i), 32'(out_valid), 1);
      checkOutput($sformatf("stream%0d data", i),  32'(out_data),  32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    checkOutput("stream drained", 32'(out_valid), 0);

    // Reset mid-stream with two entries buffered
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_PASS, 4'd5, 4'd0);
    step();
    applyStimulus(1'b1, OP_PASS, 4'd6, 4'd0);
    step();
    in_valid = 1'b0;
    checkOutput("mid full", 32'(in_ready), 0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid rst valid", 32'(out_valid), 0);
    checkOutput("mid rst data",  32'(out_data),  0);
    checkOutput("mid rst ready", 32'(in_ready),  1);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    checkOutput("mid post valid", 32'(out_valid), 0);
    checkOutput("mid post data",  32'(out_data),  0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
